// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream for fifo_rd_ctrl.
// master is the controller side; slave is the FIFO/consumer side.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DWIDTH = 8
) ();
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a 1-cycle-latency synchronous FIFO with a 2-entry skid buffer.
// Optional statistics counters are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_ctrl #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  fifo_rd_ctrl_if.master    bus,
`ifdef FIFO_RD_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       word_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q;
  logic              inflight_q;
  logic              valid_q;
  logic [1:0]        occ_q;
  logic [DWIDTH-1:0] head_q;
  logic [DWIDTH-1:0] tail_q;

  logic              pop;
  logic              capture;
  logic              rd_en;
  logic [2:0]        credit;

  assign pop     = valid_q & bus.m_ready;
  assign capture = inflight_q;

  // Words held or on their way may not exceed the two skid slots after this cycle's pop.
  always_comb begin
    credit = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_en  = rst & en & ~bus.fifo_empty & (credit < (3'd2 + {2'b00, pop}));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      unique case (state_q)
        StEmpty: begin
          if (capture) begin
            head_q  <= bus.fifo_dout;
            state_q <= StOne;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        StOne: begin
          if (capture && !pop) begin
            tail_q  <= bus.fifo_dout;
            state_q <= StTwo;
            occ_q   <= 2'd2;
          end else if (!capture && pop) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
          end else if (capture && pop) begin
            head_q  <= bus.fifo_dout;
          end
        end
        StTwo: begin
          // The credit rule keeps capture from coinciding with this state.
          if (pop) begin
            head_q  <= tail_q;
            state_q <= StOne;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid_q;
  assign bus.m_data     = head_q;
  assign occ            = occ_q;

`ifdef FIFO_RD_STATS_EN
  logic [15:0] word_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (stats_clr) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && (word_cnt_q != 16'hFFFF)) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (valid_q && !bus.m_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed vector tables plus randomized traffic
// checked against a word-count / ordered-queue reference model.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] occ;
`ifdef FIFO_RD_STATS_EN
  logic        stats_clr;
  logic [15:0] word_cnt;
  logic [15:0] stall_cnt;
`endif

  fifo_rd_ctrl_if #(.DWIDTH(8)) bus ();

  fifo_rd_ctrl #(.DWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
`ifdef FIFO_RD_STATS_EN
    .stats_clr (stats_clr),
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt),
`endif
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO with 1-cycle read latency.
  logic [7:0] q[$];
  always @(posedge clk) begin
    if (bus.fifo_rd_en && q.size() > 0) bus.fifo_dout <= q.pop_front();
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: every word ever pushed, in order, not yet delivered.
  logic [7:0] expq[$];
  int         reads = 0;
  int         pops = 0;
  int         prev_rd = 0;
  logic [7:0] last_word = 8'h00;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic tick(input bit e, input bit r, input bit p, input logic [7:0] d);
    int occ_e;
    bit pop_e;
    bit rd_e;
    @(negedge clk);
    if (p) begin
      q.push_back(d);
      expq.push_back(d);
    end
    bus.fifo_empty = (q.size() == 0);
    en = e;
    bus.m_ready = r;
    #1;
    occ_e = reads - prev_rd - pops;
    chk("occ", 32'(occ), occ_e);
    chk("m_valid", 32'(bus.m_valid), 32'(occ_e > 0));
    if (occ_e > 0) chk("m_data", 32'(bus.m_data), expq.size() > 0 ? 32'(expq[0]) : 32'hDEADBEEF);
    else chk("m_data_hold", 32'(bus.m_data), 32'(last_word));
    pop_e = (occ_e > 0) && r;
    rd_e = e && (q.size() != 0) && (occ_e + prev_rd - int'(pop_e) < 2);
    chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rd_e));
    assert (int'(occ) + prev_rd <= 2) else $error("skid buffer overflow");
    if (pop_e && expq.size() > 0) last_word = expq.pop_front();
    pops += int'(pop_e);
    reads += int'(rd_e);
    prev_rd = int'(rd_e);
  endtask

  task automatic flush();
    q.delete();
    expq.delete();
    bus.fifo_empty = 1'b1;
  endtask

  typedef struct {
    bit         push;
    logic [7:0] din;
    bit         e;
    bit         r;
    bit         x_rd;
    bit         x_valid;
    bit         x_chk_data;
    logic [7:0] x_data;
    logic [1:0] x_occ;
  } vec_t;

  vec_t sw[5];
  vec_t bp[10];

  initial begin
    // push din  en rdy | rd val chk data occ
    sw[0] = '{1, 8'hA5, 1, 1, 1, 0, 0, 8'h00, 2'd0};
    sw[1] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 2'd0};
    sw[2] = '{0, 8'h00, 1, 1, 0, 1, 1, 8'hA5, 2'd1};
    sw[3] = '{0, 8'h00, 1, 1, 0, 0, 1, 8'hA5, 2'd0};
    sw[4] = '{0, 8'h00, 1, 1, 0, 0, 1, 8'hA5, 2'd0};

    bp[0] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0};
    bp[1] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0};
    bp[2] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h01, 2'd1};
    bp[3] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h01, 2'd2};
    bp[4] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h01, 2'd2};
    bp[5] = '{0, 8'h00, 1, 1, 1, 1, 1, 8'h01, 2'd2};
    bp[6] = '{0, 8'h00, 1, 1, 1, 1, 1, 8'h02, 2'd1};
    bp[7] = '{0, 8'h00, 1, 1, 0, 1, 1, 8'h03, 2'd1};
    bp[8] = '{0, 8'h00, 1, 1, 0, 1, 1, 8'h04, 2'd1};
    bp[9] = '{0, 8'h00, 1, 1, 0, 0, 1, 8'h04, 2'd0};

    rst = 1'b0;
    en = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout = 8'h00;
`ifdef FIFO_RD_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("reset_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("reset_valid", 32'(bus.m_valid), 0);
    chk("reset_data", 32'(bus.m_data), 0);
    chk("reset_occ", 32'(occ), 0);
    @(negedge clk);
    rst = 1'b1;
    tick(0, 1, 0, 8'h00);

    // Single word
    for (int i = 0; i < $size(sw); i++) begin
      tick(sw[i].e, sw[i].r, sw[i].push, sw[i].din);
      chk("single_rd_en", 32'(bus.fifo_rd_en), 32'(sw[i].x_rd));
      chk("single_valid", 32'(bus.m_valid), 32'(sw[i].x_valid));
      chk("single_occ", 32'(occ), 32'(sw[i].x_occ));
      if (sw[i].x_chk_data) chk("single_data", 32'(bus.m_data), 32'(sw[i].x_data));
    end

    // Streaming 16 words
    for (int i = 1; i <= 16; i++) tick(0, 1, 1, 8'(i));
    for (int k = 0; k < 18; k++) begin
      tick(1, 1, 0, 8'h00);
      chk("stream_valid", 32'(bus.m_valid), 32'(k >= 2));
      if (k >= 2) chk("stream_data", 32'(bus.m_data), 32'(k - 1));
    end
    tick(0, 1, 0, 8'h00);

    // Backpressure
    for (int i = 1; i <= 4; i++) tick(0, 1, 1, 8'(i));
    for (int i = 0; i < $size(bp); i++) begin
      tick(bp[i].e, bp[i].r, bp[i].push, bp[i].din);
      chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'(bp[i].x_rd));
      chk("bp_valid", 32'(bus.m_valid), 32'(bp[i].x_valid));
      chk("bp_occ", 32'(occ), 32'(bp[i].x_occ));
      if (bp[i].x_chk_data) chk("bp_data", 32'(bus.m_data), 32'(bp[i].x_data));
    end

    // Empty gating, then en dropped after one read
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 8'h00);
      chk("empty_rd_en", 32'(bus.fifo_rd_en), 0);
    end
    tick(0, 1, 1, 8'hAA);
    tick(0, 1, 1, 8'hBB);
    tick(1, 1, 0, 8'h00);
    chk("gate_first_rd", 32'(bus.fifo_rd_en), 1);
    begin
      int nvalid = 0;
      for (int i = 0; i < 5; i++) begin
        tick(0, 1, 0, 8'h00);
        chk("gate_no_rd", 32'(bus.fifo_rd_en), 0);
        if (bus.m_valid) begin
          nvalid++;
          chk("gate_data", 32'(bus.m_data), 32'hAA);
        end
      end
      chk("gate_one_word", nvalid, 1);
      chk("gate_fifo_left", q.size(), 1);
    end
    flush();

    // Reset mid-transfer
    tick(0, 0, 1, 8'h11);
    tick(0, 0, 1, 8'h22);
    tick(0, 0, 1, 8'h33);
    tick(1, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("midrst_valid", 32'(bus.m_valid), 0);
    chk("midrst_occ", 32'(occ), 0);
    chk("midrst_data", 32'(bus.m_data), 0);
    reads = 0;
    pops = 0;
    prev_rd = 0;
    last_word = 8'h00;
    expq = q;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 8'h00);
    flush();

`ifdef FIFO_RD_STATS_EN
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 8'(8'h50 + i));
    stats_clr = 1'b1;
    tick(0, 1, 0, 8'h00);
    stats_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 8'h00);
    chk("word_cnt", 32'(word_cnt), 5);
    chk("stall_cnt", 32'(stall_cnt), 3);
    stats_clr = 1'b1;
    tick(0, 1, 0, 8'h00);
    stats_clr = 1'b0;
    tick(0, 1, 0, 8'h00);
    chk("word_cnt_clr", 32'(word_cnt), 0);
    chk("stall_cnt_clr", 32'(stall_cnt), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
           8'($urandom));
    end
    for (int i = 0; i < 300 && expq.size() > 0; i++) tick(1, 1, 0, 8'h00);
    chk("drained", expq.size(), 0);
    tick(1, 1, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's synchronous FIFO (1-cycle read latency).
- Drains the FIFO and presents its words on a valid/ready output stream.
- A 2-entry skid buffer sustains one word per cycle under backpressure.
- Sits between the FIFO read port (rd_en/dout/empty) and any downstream consumer.

Parameters:
- DWIDTH, 8, data width; must equal the FIFO din/dout width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- en  input  1  read enable; 0 stops new FIFO reads, buffered and in-flight words still complete.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DWIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_rd_en  output  1  FIFO read strobe.
- m_valid  output  1  output word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DWIDTH  output word (head of the skid buffer).
- occ  output  2  skid-buffer occupancy, 0..2, for debug.

Behaviour:
- Reset (rst=0, asynchronous): fifo_rd_en=0, m_valid=0, m_data=0, occ=0, inflight=0, state=EMPTY. Any in-flight FIFO word is discarded.
- pop = m_valid && m_ready.
- fifo_rd_en = en && !fifo_empty && (occ + inflight - pop < 2).
  - Combinational from registered state plus fifo_empty, en and m_ready.
  - Never asserted while fifo_empty=1.
- inflight: register, equals fifo_rd_en from the previous cycle. When inflight=1, fifo_dout is captured at the next rising edge.
- Skid buffer: 2-entry FIFO of DWIDTH bits (head and tail registers). The capture writes to the tail; pop removes the head.
- FSM on occupancy:
  - EMPTY: capture -> ONE.
  - ONE: capture without pop -> TWO; pop without capture -> EMPTY; capture with pop -> ONE, new word becomes head.
  - TWO: pop -> ONE, tail shifts to head; capture is impossible here because of the credit rule.
- m_valid=1 exactly in states ONE and TWO. m_data=head. m_data holds its last value when m_valid=0 and is 0 after reset.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_valid hold.
- Latency: word in FIFO, en=1, buffer empty, rd_en in cycle N -> m_valid=1 with that word in cycle N+2.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle with no bubbles after the first.
- Ordering: words leave in exact FIFO order; no drops and no duplicates.
- en falling: no new rd_en from the same cycle. An outstanding in-flight word is still captured, and buffered words drain normally.
- Overflow is impossible: occ + inflight never exceeds 2. A bench assertion checks this.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- Defined:
  - Adds output word_cnt[15:0], incremented on each pop, saturating at 16'hFFFF.
  - Adds output stall_cnt[15:0], incremented each cycle with m_valid=1 and m_ready=0, saturating at 16'hFFFF.
  - Adds input stats_clr; a synchronous clear that takes priority over increment.
  - Both counters reset to 0 on rst.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-transfer: FIFO holds 3 words, rd_en in flight, rst pulsed low between edges -> fifo_rd_en, m_valid, occ and m_data read 0 immediately; no spurious word after release.
- Single word: write 8'hA5, en=1, m_ready=1 -> fifo_rd_en high one cycle; m_valid high one cycle, 2 cycles later, with m_data=8'hA5; occ returns to 0.
- Streaming: write 8'h01..8'h10 (16 words), m_ready=1 -> m_valid continuous for 16 consecutive cycles, data 01..10 in order.
- Backpressure: 4 words queued, m_ready=0 -> occ reaches 2; fifo_rd_en stays 0 afterwards; m_data holds 8'h01. Then m_ready=1 -> 01,02,03,04 delivered back-to-back.
- Empty/en gating: fifo_empty=1 -> fifo_rd_en never asserts. en dropped the cycle after one rd_en -> exactly that one word delivered, no further reads.
- With FIFO_RD_STATS_EN: 5 pops plus 3 stalled cycles -> word_cnt=5, stall_cnt=3; stats_clr -> both 0 on the next cycle.
